// File: rtl/board_mem_arbiter_if.sv
// rtl/board_mem_arbiter_if.sv - client bus bundle for the game-board store arbiter
// Purpose: carries the video, move-writer, scanner and clear-sweep signals between the clients and the
//   board store. The slave modport is used by board_mem_arbiter and the master modport by the clients.
// Parameter: ADDR_W - cell address width.
// Signals:
//   vid_req/vid_addr -> vid_data/vid_stall       renderer reads
//   wr_req/wr_addr/wr_data -> wr_gnt/wr_rej      move writes
//   sc_req/sc_addr -> sc_gnt/sc_data/sc_valid    win-line scanner reads
//   clr_req -> clr_busy/clr_done                 board-clear sweep
interface board_mem_arbiter_if #(
  parameter int ADDR_W = 7
);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [1:0]        vid_data;
  logic              vid_stall;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        wr_data;
  logic              wr_gnt;
  logic              wr_rej;
  logic              sc_req;
  logic [ADDR_W-1:0] sc_addr;
  logic              sc_gnt;
  logic [1:0]        sc_data;
  logic              sc_valid;
  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;

  modport slave (
    input  vid_req, vid_addr, wr_req, wr_addr, wr_data, sc_req, sc_addr, clr_req,
    output vid_data, vid_stall, wr_gnt, wr_rej, sc_gnt, sc_data, sc_valid, clr_busy, clr_done
  );

  modport master (
    output vid_req, vid_addr, wr_req, wr_addr, wr_data, sc_req, sc_addr, clr_req,
    input  vid_data, vid_stall, wr_gnt, wr_rej, sc_gnt, sc_data, sc_valid, clr_busy, clr_done
  );
endinterface

// File: rtl/board_mem_arbiter.sv
// rtl/board_mem_arbiter.sv - 10x10 game-board store with one shared access slot per clock
// Purpose: holds the 2-bit board cells (00 empty, 01 tri, 10 circle, 11 marker) and grants one access per
//   cycle. Priority: starved writer/scanner, video, clear sweep, then writer/scanner in round-robin order.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset (clears the board and aborts any sweep)
//   bus    - board_mem_arbiter_if.slave: video, writer, scanner and clear-sweep signals
// Configuration macro: OCCUPIED_CHECK_EN - refuse writes of a non-empty value onto a non-empty cell.
module board_mem_arbiter #(
  parameter int CELLS    = 100,
  parameter int ADDR_W   = 7,
  parameter int MAX_WAIT = 8,
  parameter int WAIT_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  board_mem_arbiter_if.slave   bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

  logic [1:0]        mem_q [CELLS];
  state_t            state_q;
  logic [ADDR_W-1:0] sweep_q;
  logic [WAIT_W-1:0] wr_wait_q, wr_wait_d;
  logic [WAIT_W-1:0] sc_wait_q, sc_wait_d;
  logic              rr_sc_q, rr_sc_d;  // 0: writer wins the next tie, 1: scanner wins
  logic [1:0]        vid_data_q, sc_data_q;
  logic              vid_stall_q, sc_valid_q, clr_busy_q, clr_done_q;

  logic in_clear, wr_starved, sc_starved;
  logic grant_wr, grant_sc, grant_vid, grant_clr;
  logic wr_rej, wr_lands;
  logic [1:0] wr_cur;

  // Out-of-range addresses read as empty and never index the array.
  function automatic logic [1:0] rd_cell(input logic [ADDR_W-1:0] a);
    return (a <= LAST_ADDR) ? mem_q[a] : 2'b00;
  endfunction

  assign in_clear   = (state_q == S_CLEAR);
  // Writer and scanner are frozen during the sweep, so starvation cannot preempt it either.
  assign wr_starved = bus.wr_req && (wr_wait_q == WAIT_MAX) && !in_clear;
  assign sc_starved = bus.sc_req && (sc_wait_q == WAIT_MAX) && !in_clear;

  always_comb begin
    grant_wr  = 1'b0;
    grant_sc  = 1'b0;
    grant_vid = 1'b0;
    grant_clr = 1'b0;
    if (wr_starved && sc_starved) begin
      grant_wr = !rr_sc_q;
      grant_sc = rr_sc_q;
    end else if (wr_starved) begin
      grant_wr = 1'b1;
    end else if (sc_starved) begin
      grant_sc = 1'b1;
    end else if (bus.vid_req) begin
      grant_vid = 1'b1;
    end else if (in_clear) begin
      grant_clr = 1'b1;
    end else if (bus.wr_req && bus.sc_req) begin
      grant_wr = !rr_sc_q;
      grant_sc = rr_sc_q;
    end else begin
      grant_wr = bus.wr_req;
      grant_sc = bus.sc_req;
    end
  end

  assign wr_cur = rd_cell(bus.wr_addr);
`ifdef OCCUPIED_CHECK_EN
  // Erasing (wr_data 00) always goes through; placing a piece needs an empty cell.
  assign wr_rej = grant_wr && (bus.wr_data != 2'b00) && (wr_cur != 2'b00);
`else
  assign wr_rej = 1'b0;
`endif
  assign wr_lands = grant_wr && (bus.wr_addr <= LAST_ADDR) && !wr_rej;

  always_comb begin
    wr_wait_d = wr_wait_q;
    sc_wait_d = sc_wait_q;
    rr_sc_d   = rr_sc_q;
    if (!bus.wr_req || grant_wr)          wr_wait_d = '0;
    else if (!in_clear && wr_wait_q != WAIT_MAX) wr_wait_d = wr_wait_q + WAIT_W'(1);
    if (!bus.sc_req || grant_sc)          sc_wait_d = '0;
    else if (!in_clear && sc_wait_q != WAIT_MAX) sc_wait_d = sc_wait_q + WAIT_W'(1);
    if (grant_wr)      rr_sc_d = 1'b1;
    else if (grant_sc) rr_sc_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CELLS; i++) mem_q[i] <= 2'b00;
      state_q     <= S_IDLE;
      sweep_q     <= '0;
      wr_wait_q   <= '0;
      sc_wait_q   <= '0;
      rr_sc_q     <= 1'b0;
      vid_data_q  <= 2'b00;
      sc_data_q   <= 2'b00;
      vid_stall_q <= 1'b0;
      sc_valid_q  <= 1'b0;
      clr_busy_q  <= 1'b0;
      clr_done_q  <= 1'b0;
    end else begin
      wr_wait_q   <= wr_wait_d;
      sc_wait_q   <= sc_wait_d;
      rr_sc_q     <= rr_sc_d;
      // A preempted video slot keeps the old pixel data and flags the stall next cycle.
      vid_stall_q <= bus.vid_req && !grant_vid;
      sc_valid_q  <= grant_sc;
      if (grant_vid) vid_data_q <= rd_cell(bus.vid_addr);
      if (grant_sc)  sc_data_q  <= rd_cell(bus.sc_addr);
      if (wr_lands)  mem_q[bus.wr_addr] <= bus.wr_data;
      if (grant_clr) mem_q[sweep_q] <= 2'b00;

      case (state_q)
        S_IDLE: begin
          clr_done_q <= 1'b0;
          if (bus.clr_req) begin
            state_q    <= S_CLEAR;
            sweep_q    <= '0;
            clr_busy_q <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (grant_clr) begin
            if (sweep_q == LAST_ADDR) begin
              state_q    <= S_DONE;
              clr_busy_q <= 1'b0;
              clr_done_q <= 1'b1;
            end else begin
              sweep_q <= sweep_q + ADDR_W'(1);
            end
          end
        end
        default: begin
          state_q    <= S_IDLE;
          clr_busy_q <= 1'b0;
          clr_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.vid_data  = vid_data_q;
  assign bus.vid_stall = vid_stall_q;
  assign bus.wr_gnt    = grant_wr;
  assign bus.wr_rej    = wr_rej;
  assign bus.sc_gnt    = grant_sc;
  assign bus.sc_data   = sc_data_q;
  assign bus.sc_valid  = sc_valid_q;
  assign bus.clr_busy  = clr_busy_q;
  assign bus.clr_done  = clr_done_q;

endmodule
